// File: rtl/imem_loader_pkg.sv
// Shared IMem sizing and loader state encodings used by the loader, IMem and IF.

package imem_loader_pkg;

  localparam int unsigned IMEM_DEPTH = 256;
  localparam int unsigned IMEM_AW    = 8;

  localparam logic [2:0] LD_LEN_HI = 3'd0;
  localparam logic [2:0] LD_LEN_LO = 3'd1;
  localparam logic [2:0] LD_DATA   = 3'd2;
  localparam logic [2:0] LD_DONE   = 3'd3;
  localparam logic [2:0] LD_ERR    = 3'd4;

  typedef enum logic [2:0] {
    StLenHi = LD_LEN_HI,
    StLenLo = LD_LEN_LO,
    StData  = LD_DATA,
    StDone  = LD_DONE,
    StErr   = LD_ERR
  } ld_state_e;

  // A zero-length image is legal; only counts beyond the memory size are rejected.
  function automatic logic len_too_big(input logic [15:0] n, input int unsigned depth);
    return 32'(n) > depth;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Shifts stream bytes into a little-endian word and pulses word_ready_o on the final byte.

module imem_loader_byte_packer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             valid_i,
  input  logic [7:0]       byte_i,
  output logic [WIDTH-1:0] word_o,
  output logic             word_ready_o
);

  localparam int unsigned BYTES = WIDTH / 8;
  localparam int unsigned CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] shifted;
  logic             last;

  // New bytes enter at the top, so the first byte lands in bits 7:0 once the word is full.
  if (BYTES > 1) begin : g_multi
    assign shifted = {byte_i, sr_q[WIDTH-1:8]};
  end else begin : g_single
    assign shifted = byte_i;
  end

  assign last         = (cnt_q == CW'(BYTES - 1));
  assign word_o       = shifted;
  assign word_ready_o = valid_i && !clr_i && last;

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clr_i) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (valid_i) begin
      sr_d  = shifted;
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program image into IMem and holds the core in reset until done.

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = IMEM_DEPTH,
  parameter int unsigned AW    = IMEM_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             load_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_data,
  output logic             core_rst_n,
  output logic             done,
  output logic             err
);

  ld_state_e        state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      word_cnt_q, word_cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;

  logic             accept;
  logic [15:0]      n_full;
  logic             all_issued;
  logic             pk_valid;
  logic             pk_clr;
  logic [WIDTH-1:0] pk_word;
  logic             pk_ready;

  assign accept     = in_valid && in_ready;
  assign n_full     = {len_q[15:8], in_data};
  assign all_issued = (word_cnt_q == len_q);
  assign pk_valid   = accept && (state_q == StData);
  assign pk_clr     = (state_q != StData);

  imem_loader_byte_packer #(
    .WIDTH (WIDTH)
  ) u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (pk_clr),
    .valid_i      (pk_valid),
    .byte_i       (in_data),
    .word_o       (pk_word),
    .word_ready_o (pk_ready)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLenHi: if (accept) state_d = StLenLo;
      StLenLo: begin
        if (accept) begin
          if (n_full == 16'd0)                 state_d = StDone;
          else if (len_too_big(n_full, DEPTH)) state_d = StErr;
          else                                 state_d = StData;
        end
      end
      // Leave only once the final write register has been presented to IMem.
      StData:  if (all_issued) state_d = StDone;
      StDone:  if (load_req) state_d = StLenHi;
      StErr:   state_d = StErr;
      default: state_d = StLenHi;
    endcase
  end

  always_comb begin
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    wdata_d    = wdata_q;
    if (accept && state_q == StLenHi) len_d = {in_data, 8'h00};
    if (accept && state_q == StLenLo) len_d = n_full;
    if (pk_ready) begin
      we_d       = 1'b1;
      addr_d     = word_cnt_q[AW-1:0];
      wdata_d    = pk_word;
      word_cnt_d = word_cnt_q + 16'd1;
    end
    if (state_q == StDone && load_req) begin
      addr_d     = '0;
      word_cnt_d = '0;
    end
  end

  always_comb begin
    in_ready   = 1'b0;
    done       = 1'b0;
    core_rst_n = 1'b0;
    err        = 1'b0;
    unique case (state_q)
      StLenHi, StLenLo: in_ready = 1'b1;
      StData:           in_ready = !all_issued;
      StDone: begin
        done       = 1'b1;
        core_rst_n = 1'b1;
      end
      StErr:            err = 1'b1;
      default:          in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StLenHi;
      len_q      <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
    end
  end

  assign mem_we   = we_q;
  assign mem_addr = addr_q;
  assign mem_data = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized image loads against a word-level model of the stream format.

module tb_imem_loader;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             load_req = 1'b0;
  logic             in_ready;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_data;
  logic             core_rst_n;
  logic             done;
  logic             err;

  always #5 clk = ~clk;

  imem_loader #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .load_req   (load_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .core_rst_n (core_rst_n),
    .done       (done),
    .err        (err)
  );

  int checks = 0;
  int errors = 0;

  // Write log captured on the edge that consumes each write cycle.
  int unsigned log_addr[$];
  logic [31:0] log_data[$];
  int          b2b = 0;
  logic        we_prev = 1'b0;

  always @(posedge clk) begin
    if (mem_we) begin
      log_addr.push_back(int'(mem_addr));
      log_data.push_back(mem_data);
      if (we_prev) b2b <= b2b + 1;
    end
    we_prev <= mem_we;
  end

  logic [7:0] pay[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    w        = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    else @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_req();
    load_req = 1'b1;
    tick(1);
    load_req = 1'b0;
    chk("req_done_clr", 64'(done), 64'd0);
    chk("req_core_rst", 64'(core_rst_n), 64'd0);
    chk("req_in_ready", 64'(in_ready), 64'd1);
  endtask

  // gap: 0 = back-to-back, 1 = one idle cycle between bytes, 2 = random idle 0..3.
  task automatic do_load(input logic [15:0] n, input int gap, output int base);
    int          got;
    logic [31:0] exp_w;
    base = log_addr.size();
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    if (n == 16'd0) begin
      chk("n0_done", 64'(done), 64'd1);
      chk("n0_core_rst", 64'(core_rst_n), 64'd1);
    end else begin
      for (int i = 0; i < pay.size(); i++) begin
        if (gap == 1) tick(1);
        else if (gap == 2) tick(int'($urandom_range(0, 3)));
        send_byte(pay[i]);
      end
      chk("last_we", 64'(mem_we), 64'd1);
      chk("last_addr", 64'(mem_addr), 64'(n - 16'd1));
      chk("last_done_low", 64'(done), 64'd0);
      chk("last_core_low", 64'(core_rst_n), 64'd0);
      tick(1);
      chk("post_we", 64'(mem_we), 64'd0);
      chk("post_done", 64'(done), 64'd1);
      chk("post_core_rst", 64'(core_rst_n), 64'd1);
    end
    tick(1);
    got = log_addr.size() - base;
    chk("write_count", 64'(got), 64'(n));
    for (int i = 0; i < int'(n) && i < got; i++) begin
      exp_w = {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]};
      chk("word_addr", 64'(log_addr[base+i]), 64'(i));
      chk("word_data", 64'(log_data[base+i]), 64'(exp_w));
    end
  endtask

  initial begin
    int          base;
    int          n;
    int          wr_before;
    logic [31:0] w;

    // Reset state.
    rst_n = 1'b0;
    tick(2);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_data", 64'(mem_data), 64'd0);
    chk("rst_core", 64'(core_rst_n), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    tick(1);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Three words, continuous valid.
    pay.delete();
    for (int i = 1; i <= 12; i++) pay.push_back(8'(i));
    do_load(16'd3, 0, base);
    w = log_data[base];
    chk("w0_const", 64'(w), 64'h04030201);
    w = log_data[base+2];
    chk("w2_const", 64'(w), 64'h0C0B0A09);

    // Empty image.
    pulse_req();
    pay.delete();
    do_load(16'd0, 0, base);

    // Two words with toggling valid.
    pulse_req();
    pay.delete();
    for (int i = 0; i < 8; i++) pay.push_back(8'($urandom));
    do_load(16'd2, 1, base);

    // Random lengths and gaps.
    for (int k = 0; k < 4; k++) begin
      pulse_req();
      n = int'($urandom_range(1, 24));
      pay.delete();
      for (int i = 0; i < 4 * n; i++) pay.push_back(8'($urandom));
      do_load(16'(n), 2, base);
    end

    // Largest legal image.
    pulse_req();
    pay.delete();
    for (int i = 0; i < 4 * int'(DEPTH); i++) pay.push_back(8'($urandom));
    do_load(16'(DEPTH), 0, base);
    chk("b2b_we", 64'(b2b), 64'd0);

    // Reset after five data bytes, then reload.
    pulse_req();
    send_byte(8'h00);
    send_byte(8'h02);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_we", 64'(mem_we), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    pay.delete();
    pay.push_back(8'hAA);
    pay.push_back(8'hBB);
    pay.push_back(8'hCC);
    pay.push_back(8'hDD);
    do_load(16'd1, 0, base);
    w = log_data[base];
    chk("fresh_const", 64'(w), 64'hDDCCBBAA);

    // Reset wins over a simultaneous load_req.
    rst_n    = 1'b0;
    load_req = 1'b1;
    tick(1);
    load_req = 1'b0;
    rst_n    = 1'b1;
    chk("rstreq_done", 64'(done), 64'd0);
    chk("rstreq_ready", 64'(in_ready), 64'd1);

    // Oversized length.
    send_byte(8'h01);
    send_byte(8'h01);
    chk("err_set", 64'(err), 64'd1);
    chk("err_ready", 64'(in_ready), 64'd0);
    chk("err_core", 64'(core_rst_n), 64'd0);
    chk("err_done", 64'(done), 64'd0);
    wr_before = log_addr.size();
    in_valid  = 1'b1;
    in_data   = 8'h55;
    tick(5);
    in_valid = 1'b0;
    load_req = 1'b1;
    tick(1);
    load_req = 1'b0;
    tick(1);
    chk("err_no_write", 64'(log_addr.size() - wr_before), 64'd0);
    chk("err_sticky", 64'(err), 64'd1);
    chk("err_ready_hold", 64'(in_ready), 64'd0);
    chk("err_core_hold", 64'(core_rst_n), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
